// File: rtl/vending_if.sv
// Coin acceptor / actuator bundle for vending_ctrl.
//   master: coin acceptor and actuator side. It drives coin_valid, coin_type
//           and cancel, and receives credit, purchase, change_pulse,
//           coin_reject and busy.
//   slave : vending_ctrl side. It has the opposite directions.
interface vending_if #(
    parameter int unsigned CREDIT_W = 8
);
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                purchase;
    logic                change_pulse;
    logic                coin_reject;
    logic                busy;

    modport master (
        output coin_valid, coin_type, cancel,
        input  credit, purchase, change_pulse, coin_reject, busy
    );

    modport slave (
        input  coin_valid, coin_type, cancel,
        output credit, purchase, change_pulse, coin_reject, busy
    );
endinterface

// File: rtl/vending_ctrl.sv
// Parametrised vending controller.
// It accumulates credit from three coin types. When the credit reaches PRICE
// it vends automatically. Surplus credit, or all credit on cancel, goes back
// as a train of change_pulse strobes. Each strobe is worth CHANGE_UNIT.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : vending_if.slave
//           inputs  coin_valid, coin_type[1:0], cancel
//           outputs credit[CREDIT_W-1:0], purchase, change_pulse,
//                   coin_reject, busy
module vending_ctrl #(
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned PRICE       = 20,
    parameter int unsigned COIN_A      = 10,
    parameter int unsigned COIN_B      = 20,
    parameter int unsigned COIN_C      = 50,
    parameter int unsigned MAX_CREDIT  = 100,
    parameter int unsigned CHANGE_UNIT = 10
) (
    input  logic      clk,
    input  logic      reset,
    vending_if.slave  bus
);
    localparam int unsigned SUM_W = CREDIT_W + 1;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] COLLECT = 2'b01;
    localparam logic [1:0] VEND    = 2'b10;
    localparam logic [1:0] REFUND  = 2'b11;

    localparam logic [SUM_W-1:0]    VAL_A   = SUM_W'(COIN_A);
    localparam logic [SUM_W-1:0]    VAL_B   = SUM_W'(COIN_B);
    localparam logic [SUM_W-1:0]    VAL_C   = SUM_W'(COIN_C);
    localparam logic [SUM_W-1:0]    MAX_V   = SUM_W'(MAX_CREDIT);
    localparam logic [SUM_W-1:0]    PRICE_S = SUM_W'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                coin_reject_q, coin_reject_d;

    logic [SUM_W-1:0]    coin_value;
    logic [SUM_W-1:0]    sum;

    always_comb begin
        coin_value = '0;
        case (bus.coin_type)
            2'b01:   coin_value = VAL_A;
            2'b10:   coin_value = VAL_B;
            2'b11:   coin_value = VAL_C;
            default: coin_value = '0;
        endcase
        // Keep the carry bit so that an overflowing sum is still compared
        // correctly against MAX_CREDIT.
        sum = {1'b0, credit_q} + coin_value;
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = 1'b0;

        case (state_q)
            IDLE, COLLECT: begin
                if ((state_q == COLLECT) && bus.cancel) begin
                    // Cancel wins over a coin in the same cycle. That coin is rejected.
                    state_d       = REFUND;
                    coin_reject_d = bus.coin_valid;
                end else if (bus.coin_valid) begin
                    if ((bus.coin_type == 2'b00) || (sum > MAX_V)) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = (sum >= PRICE_S) ? VEND : COLLECT;
                    end
                end
            end
            VEND: begin
                coin_reject_d = bus.coin_valid;
                credit_d      = credit_q - PRICE_C;
                state_d       = (credit_q > PRICE_C) ? REFUND : IDLE;
            end
            REFUND: begin
                coin_reject_d = bus.coin_valid;
                // The last pulse goes out while credit holds one unit or less.
                // Any sub-unit residue is dropped at the same time.
                if (credit_q <= UNIT_C) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    credit_d = credit_q - UNIT_C;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.purchase     = (state_q == VEND);
    assign bus.change_pulse = (state_q == REFUND);
    assign bus.busy         = (state_q == VEND) || (state_q == REFUND);
    assign bus.coin_reject  = coin_reject_q;
endmodule
